// File: rtl/ascii_bcd_updown_counter_pkg.sv
// Shared constants and helpers for the ASCII decimal up/down counter.
// Holds the digit byte width, the ASCII codes for "0" and "9", and a
// byte classifier used to validate load values.
package ascii_bcd_updown_counter_pkg;

  localparam int          DIGIT_W    = 8;
  localparam logic [7:0]  ASCII_ZERO = 8'h30;
  localparam logic [7:0]  ASCII_NINE = 8'h39;

  // True when the byte is one of the ASCII codes "0".."9".
  function automatic logic is_ascii_digit(input logic [DIGIT_W-1:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

endpackage

// File: rtl/ascii_bcd_updown_counter_digit_step.sv
// One ASCII decimal digit of the counter: applies a +1/-1 step when
// carry/borrow in is set, producing the next digit byte and carry/borrow out.
// Ports: digit_i (current byte), up_i (direction), cin_i (step request),
//        digit_o (next byte), cout_o (carry on 9->0 or borrow on 0->9).
module ascii_digit_step
  import ascii_bcd_updown_counter_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  input  logic               up_i,
  input  logic               cin_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               cout_o
);

  // Arithmetic is done directly on the ASCII code: only "0".."9" ever reach
  // this point, so +/-1 never disturbs the 0x3 upper nibble except at the
  // rollover points, which are handled explicitly.
  always_comb begin
    digit_o = digit_i;
    cout_o  = 1'b0;
    if (cin_i) begin
      if (up_i) begin
        if (digit_i == ASCII_NINE) begin
          digit_o = ASCII_ZERO;
          cout_o  = 1'b1;
        end else begin
          digit_o = digit_i + 8'd1;
        end
      end else begin
        if (digit_i == ASCII_ZERO) begin
          digit_o = ASCII_NINE;
          cout_o  = 1'b1;
        end else begin
          digit_o = digit_i - 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ascii_bcd_updown_counter.sv
// Multi-digit decimal up/down counter held as ASCII characters, MSD in the
// top byte. Registers count/done/terminal/load_error; load validation and
// wrap-or-saturate terminal handling live here.
// Ports: clock, reset (async active-low), load/load_value, enable, up;
//        count, done (sticky, saturate mode), terminal (1-cycle pulse),
//        load_error (sticky, last load had a non-digit byte).
// DIGITS is expected in 1..8; WRAP=0 saturates, WRAP=1 wraps.
module ascii_bcd_updown_counter
  import ascii_bcd_updown_counter_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b0
)
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_value,
  input  logic                      enable,
  input  logic                      up,
  output logic [DIGIT_W*DIGITS-1:0] count,
  output logic                      done,
  output logic                      terminal,
  output logic                      load_error
);

  localparam int                W        = DIGIT_W * DIGITS;
  localparam logic [W-1:0]      ALL_ZERO = {DIGITS{ASCII_ZERO}};

  logic [W-1:0]      count_q, count_d;
  logic              done_q, done_d;
  logic              term_q, term_d;
  logic              err_q, err_d;

  logic [W-1:0]      step_val;
  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] byte_ok;
  logic [DIGITS-1:0] nxt_zero;
  logic [DIGITS-1:0] nxt_nine;

  logic              load_ok;
  logic              wrap_step;
  logic              reach_term;

  // The LSD always receives the step request; carry/borrow ripples upward
  // within the same cycle.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    ascii_digit_step u_step (
      .digit_i (count_q[i*DIGIT_W +: DIGIT_W]),
      .up_i    (up),
      .cin_i   (carry[i]),
      .digit_o (step_val[i*DIGIT_W +: DIGIT_W]),
      .cout_o  (carry[i+1])
    );
    assign byte_ok[i]  = is_ascii_digit(load_value[i*DIGIT_W +: DIGIT_W]);
    assign nxt_zero[i] = (step_val[i*DIGIT_W +: DIGIT_W] == ASCII_ZERO);
    assign nxt_nine[i] = (step_val[i*DIGIT_W +: DIGIT_W] == ASCII_NINE);
  end

  assign load_ok    = &byte_ok;
  // Carry out of the MSD means the count was already at the extreme for
  // this direction, so the step is a wrap (or, saturating, a blocked step).
  assign wrap_step  = carry[DIGITS];
  assign reach_term = up ? (&nxt_nine) : (&nxt_zero);

  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    term_d  = 1'b0;
    err_d   = err_q;
    if (load) begin
      done_d = 1'b0;
      if (load_ok) begin
        count_d = load_value;
        err_d   = 1'b0;
      end else begin
        count_d = ALL_ZERO;
        err_d   = 1'b1;
      end
    end else if (enable && !done_q && !err_q) begin
      if (WRAP) begin
        count_d = step_val;
        term_d  = reach_term | wrap_step;
      end else if (wrap_step) begin
        // Already at the extreme: flag it but never under/overflow.
        term_d = 1'b1;
        done_d = 1'b1;
      end else begin
        count_d = step_val;
        if (reach_term) begin
          term_d = 1'b1;
          done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= ALL_ZERO;
      done_q  <= 1'b0;
      term_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
      term_q  <= term_d;
      err_q   <= err_d;
    end
  end

  assign count      = count_q;
  assign done       = done_q;
  assign terminal   = term_q;
  assign load_error = err_q;

endmodule
